// File: rtl/core_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_pkg : shared state codes, glyphs and measurement constants           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package core_pkg;

  localparam int          MEAS_W    = 19;
  localparam logic [18:0] MEAS_NONE = 19'h7FFFF;

  typedef enum logic [2:0] {
    DST_IDLE   = 3'b000,
    DST_WAIT   = 3'b001,
    DST_LIT    = 3'b010,
    DST_EARLY  = 3'b011,
    DST_FINISH = 3'b110
  } dst_e;

  typedef enum logic [1:0] {
    CV_IDLE  = 2'd0,
    CV_SHIFT = 2'd1,
    CV_DONE  = 2'd2
  } cv_state_e;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_R     = 7'h50;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    seg_of = SEG_0;
      4'd1:    seg_of = SEG_1;
      4'd2:    seg_of = SEG_2;
      4'd3:    seg_of = SEG_3;
      4'd4:    seg_of = SEG_4;
      4'd5:    seg_of = SEG_5;
      4'd6:    seg_of = SEG_6;
      4'd7:    seg_of = SEG_7;
      4'd8:    seg_of = SEG_8;
      4'd9:    seg_of = SEG_9;
      default: seg_of = SEG_BLANK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bin2bcd_seq : one-bit-per-clock double-dabble, 19-bit binary to 6 BCD     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module bin2bcd_seq
  import core_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [18:0] i_bin,
  output logic        o_busy,
  output logic        o_done,
  output logic [23:0] o_bcd
);

  cv_state_e   state_q, state_d;
  logic [23:0] scratch_q, scratch_d;
  logic [18:0] bin_q, bin_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [23:0] adj;

  always_comb begin
    adj = scratch_q;
    for (int n = 0; n < 6; n++) begin
      if (scratch_q[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = scratch_q[n*4 +: 4] + 4'd3;
    end

    state_d   = state_q;
    scratch_d = scratch_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    case (state_q)
      CV_IDLE: begin
        if (i_start) begin
          scratch_d = '0;
          bin_d     = i_bin;
          cnt_d     = '0;
          state_d   = CV_SHIFT;
        end
      end
      CV_SHIFT: begin
        scratch_d = {adj[22:0], bin_q[18]};
        bin_d     = {bin_q[17:0], 1'b0};
        cnt_d     = cnt_q + 5'd1;
        if (cnt_q == 5'd18) state_d = CV_DONE;
      end
      default: state_d = CV_IDLE;
    endcase
    busy_d = (state_d != CV_IDLE);
    done_d = (state_d == CV_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= CV_IDLE;
      scratch_q <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      scratch_q <= scratch_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_bcd  = scratch_q;

endmodule
`default_nettype wire

// File: rtl/core_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | core_display : reaction-time result to 6-digit multiplexed 7-seg display  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module core_display
  import core_pkg::*;
#(
  parameter int SCAN_DIV   = 16384,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [2:0]  i_dst,
  input  logic [18:0] i_measured,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic [5:0]  o_dig,
  output logic        o_busy
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       idx_q, idx_d;
  logic [18:0]      last_bin_q, last_bin_d;
  logic [23:0]      result_q, result_d;
  logic             valid_q, valid_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic [5:0]       dig_q, dig_d;

  logic        conv_busy, conv_done, capture, start;
  logic [23:0] conv_bcd;
  logic [3:0]  nib;
  logic [6:0]  glyph;
  logic        glyph_dp;

  bin2bcd_seq u_conv (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (start),
    .i_bin   (i_measured),
    .o_busy  (conv_busy),
    .o_done  (conv_done),
    .o_bcd   (conv_bcd)
  );

  always_comb begin
    capture    = !conv_busy && (i_measured != last_bin_q);
    start      = capture && (i_measured != MEAS_NONE);
    last_bin_d = capture ? i_measured : last_bin_q;
    valid_d    = valid_q;
    result_d   = result_q;
    if (capture && (i_measured == MEAS_NONE)) begin
      valid_d = 1'b0;
    end else if (conv_done) begin
      valid_d  = 1'b1;
      result_d = conv_bcd;
    end

    div_d = div_q + DIV_W'(1);
    idx_d = idx_q;
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end

    nib      = result_q[{idx_q, 2'b00} +: 4];
    glyph    = SEG_BLANK;
    glyph_dp = 1'b0;
    case (i_dst)
      DST_IDLE, DST_FINISH: begin
        if (!valid_q) begin
          glyph = SEG_DASH;
        end else begin
          // Only the two integer digits above the units get zero-blanked.
          if ((idx_q == 3'd5 && nib == 4'd0) ||
              (idx_q == 3'd4 && nib == 4'd0 && result_q[23:20] == 4'd0))
            glyph = SEG_BLANK;
          else
            glyph = seg_of(nib);
          glyph_dp = (idx_q == 3'd3);
        end
      end
      DST_EARLY: begin
        if (idx_q == 3'd5)                        glyph = SEG_E;
        else if (idx_q == 3'd4 || idx_q == 3'd3)  glyph = SEG_R;
      end
      default: glyph = SEG_BLANK;
    endcase

    seg_d = glyph ^ {7{ACTIVE_LOW}};
    dp_d  = glyph_dp ^ ACTIVE_LOW;
    dig_d = (6'b000001 << idx_q) ^ {6{ACTIVE_LOW}};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_q      <= '0;
      idx_q      <= '0;
      last_bin_q <= MEAS_NONE;
      result_q   <= '0;
      valid_q    <= 1'b0;
      seg_q      <= {7{ACTIVE_LOW}};
      dp_q       <= ACTIVE_LOW;
      dig_q      <= {6{ACTIVE_LOW}};
    end else begin
      div_q      <= div_d;
      idx_q      <= idx_d;
      last_bin_q <= last_bin_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      dig_q      <= dig_d;
    end
  end

  assign o_seg  = seg_q;
  assign o_dp   = dp_q;
  assign o_dig  = dig_q;
  assign o_busy = conv_busy;

endmodule
`default_nettype wire

// File: tb/tb_core_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_core_display : directed vectors for core_display, both polarities      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_core_display;

  localparam int SD = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  dst;
  logic [18:0] meas;
  logic [6:0]  seg, seg_n;
  logic        dp, dp_n;
  logic [5:0]  dig, dig_n;
  logic        busy, busy_n;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  core_display #(.SCAN_DIV(SD), .ACTIVE_LOW(1'b0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_dst(dst), .i_measured(meas),
    .o_seg(seg), .o_dp(dp), .o_dig(dig), .o_busy(busy)
  );

  core_display #(.SCAN_DIV(SD), .ACTIVE_LOW(1'b1)) u_dut_n (
    .i_clk(clk), .i_rst(rst), .i_dst(dst), .i_measured(meas),
    .o_seg(seg_n), .o_dp(dp_n), .o_dig(dig_n), .o_busy(busy_n)
  );

  typedef struct packed {
    logic [2:0]       dst;
    logic [18:0]      meas;
    logic [5:0][6:0]  seg;
    logic [5:0]       dp;
  } vec_t;

  vec_t tv [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Watches two full scan rounds and records what each digit showed.
  task automatic scan(output logic [5:0][6:0] s, output logic [5:0] d,
                      output int bad_inv, output int bad_hot,
                      output int bad_hold, output int busy_seen);
    logic [5:0] prev;
    int run;
    bit started;
    s = 'x; d = 'x;
    bad_inv = 0; bad_hot = 0; bad_hold = 0; busy_seen = 0;
    prev = dig; run = 0; started = 1'b0;
    repeat (12 * SD) begin
      @(negedge clk);
      if (dig !== prev) begin
        if (started && run != SD) bad_hold++;
        started = 1'b1;
        run = 1;
        prev = dig;
      end else begin
        run++;
      end
      if (!$onehot(dig)) bad_hot++;
      if ({seg_n, dp_n, dig_n} !== ~{seg, dp, dig}) bad_inv++;
      if (busy) busy_seen++;
      for (int k = 0; k < 6; k++) begin
        if (dig[k]) begin
          s[k] = seg;
          d[k] = dp;
        end
      end
    end
  endtask

  task automatic check_display(input string tag, input logic [5:0][6:0] es, input logic [5:0] ed,
                               input bit expect_idle);
    logic [5:0][6:0] s;
    logic [5:0] d;
    int bi, bh, bl, bs;
    scan(s, d, bi, bh, bl, bs);
    for (int k = 0; k < 6; k++)
      check($sformatf("%s digit%0d", tag, k), {s[k], d[k]}, {es[k], ed[k]});
    check({tag, " polarity"}, bi, 0);
    check({tag, " onehot"}, bh, 0);
    check({tag, " hold"}, bl, 0);
    if (expect_idle) check({tag, " busy_idle"}, bs, 0);
  endtask

  localparam logic [5:0][6:0] DASHES = {6{7'h40}};
  localparam logic [5:0][6:0] BLANKS = {6{7'h00}};
  localparam logic [5:0][6:0] P1234  = {7'h00, 7'h00, 7'h06, 7'h5B, 7'h4F, 7'h66};
  localparam logic [5:0][6:0] P0     = {7'h00, 7'h00, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  initial begin
    int n1, n2, gap, bad_part, bad_dash;
    bit changed;

    tv[0] = '{dst: 3'b110, meas: 19'd1234,   seg: P1234, dp: 6'b001000};
    tv[1] = '{dst: 3'b110, meas: 19'd524286, seg: {7'h6D, 7'h5B, 7'h66, 7'h5B, 7'h7F, 7'h7D}, dp: 6'b001000};
    tv[2] = '{dst: 3'b110, meas: 19'd0,      seg: P0, dp: 6'b001000};
    tv[3] = '{dst: 3'b011, meas: 19'd0,      seg: {7'h79, 7'h50, 7'h50, 7'h00, 7'h00, 7'h00}, dp: 6'b000000};
    tv[4] = '{dst: 3'b001, meas: 19'd0,      seg: BLANKS, dp: 6'b000000};
    tv[5] = '{dst: 3'b010, meas: 19'd0,      seg: BLANKS, dp: 6'b000000};
    tv[6] = '{dst: 3'b000, meas: 19'd0,      seg: P0, dp: 6'b001000};
    tv[7] = '{dst: 3'b111, meas: 19'd0,      seg: BLANKS, dp: 6'b000000};
    tv[8] = '{dst: 3'b110, meas: 19'd50123,  seg: {7'h00, 7'h6D, 7'h3F, 7'h06, 7'h5B, 7'h4F}, dp: 6'b001000};
    tv[9] = '{dst: 3'b000, meas: 19'h7FFFF,  seg: DASHES, dp: 6'b000000};

    rst = 1'b1; dst = 3'b000; meas = 19'h7FFFF;
    repeat (3) @(negedge clk);
    check("reset outputs", {seg, dp, dig, busy}, 15'd0);
    check("reset outputs inv", {seg_n, dp_n, dig_n}, 14'h3FFF);
    rst = 1'b0;

    check_display("no_result", DASHES, 6'b0, 1'b1);

    // First conversion: busy length and no partial result on the display.
    @(negedge clk);
    dst = 3'b110; meas = 19'd1234;
    n1 = 0; bad_part = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy) begin
        n1++;
        if (seg !== 7'h40 || dp !== 1'b0) bad_part++;
      end else if (n1 > 0) break;
    end
    check("busy_len", n1, 20);
    check("no_partial", bad_part, 0);

    foreach (tv[i]) begin
      dst = tv[i].dst; meas = tv[i].meas;
      repeat (25) @(negedge clk);
      check_display($sformatf("vec%0d", i), tv[i].seg, tv[i].dp, 1'b0);
    end

    // Input change while converting: first value commits, second conversion follows.
    dst = 3'b110; meas = 19'd524286;
    n1 = 0; changed = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy) n1++;
      if (n1 == 5 && !changed) begin
        meas = 19'd0;
        changed = 1'b1;
      end
      if (!busy && n1 > 0) break;
    end
    gap = 1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy) break;
      gap++;
    end
    n2 = 1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!busy) break;
      n2++;
    end
    check("mid_first_len", n1, 20);
    check("mid_gap", gap, 1);
    check("mid_second_len", n2, 20);
    check_display("mid_final", P0, 6'b001000, 1'b1);

    // Reset in the middle of a conversion discards the old result.
    dst = 3'b000; meas = 19'd1234;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad_dash = 0;
    repeat (10) begin
      @(negedge clk);
      if (seg !== 7'h40 || dp !== 1'b0 || seg_n !== 7'h3F || dp_n !== 1'b1) bad_dash++;
    end
    check("rst_dashes", bad_dash, 0);
    repeat (20) @(negedge clk);
    check_display("after_rst", P1234, 6'b001000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
